// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Fetch-stage controller. Owns the fetch PC and issues one word
//               address per cycle to a synchronous-read instruction memory.
//               The word returned one cycle later is captured into a 2-entry
//               FIFO whose head is offered to decode over valid/ready.
//               Handles redirects and flags misaligned or out-of-range fetch
//               PCs with a sticky error that halts issue until reset.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               imem_addr          - registered word address to memory
//               imem_instr         - word for the address sampled last edge
//               redirect_valid/pc  - one-cycle restart request and target
//               if_valid/ready     - handshake towards decode
//               if_pc/if_instr     - head-of-buffer PC and instruction
//               fetch_err          - sticky fault flag
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fetch_err
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]  occ_q, occ_d;
  logic [31:0] pc0_q, pc0_d, ins0_q, ins0_d;   // entry 0 is the head
  logic [31:0] pc1_q, pc1_d, ins1_q, ins1_d;
  logic        err_q, err_d;

  logic        pop;
  logic        push;
  logic        pc_legal;
  logic        redir_legal;
  logic        redir_take;
  logic [1:0]  occ_after_pop;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    occ_d         = occ_q;
    pc0_d         = pc0_q;
    ins0_d        = ins0_q;
    pc1_d         = pc1_q;
    ins1_d        = ins1_q;
    err_d         = err_q;
    push          = 1'b0;

    pop           = (occ_q != 2'd0) && if_ready;
    pc_legal      = (fetch_pc_q[1:0] == 2'b00) && (fetch_pc_q <= LAST_PC);
    redir_legal   = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= LAST_PC);
    redir_take    = (state_q == ST_RUN) && redirect_valid;
    occ_after_pop = occ_q - {1'b0, pop};

    // A pop always completes, even in a redirect cycle: shift entry 1 forward.
    if (pop) begin
      pc0_d  = pc1_q;
      ins0_d = ins1_q;
    end

    if (redir_take) begin
      // Flush the buffer and drop the word returning this cycle.
      occ_d = 2'd0;
      if (redir_legal) begin
        fetch_pc_d = redirect_pc;
      end else begin
        err_d   = 1'b1;
        state_d = ST_HALT;
      end
    end else begin
      push = inflight_q;
      if (push) begin
        if (occ_after_pop == 2'd0) begin
          pc0_d  = inflight_pc_q;
          ins0_d = imem_instr;
        end else begin
          pc1_d  = inflight_pc_q;
          ins1_d = imem_instr;
        end
      end
      occ_d = occ_after_pop + {1'b0, push};

      if (state_q == ST_RUN) begin
        if (!pc_legal) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else if (occ_d < 2'd2) begin
          // occ_d equals occ + inflight - pop, so this is the room check.
          inflight_d    = 1'b1;
          inflight_pc_d = fetch_pc_q;
          fetch_pc_d    = fetch_pc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      occ_q         <= 2'd0;
      pc0_q         <= '0;
      ins0_q        <= '0;
      pc1_q         <= '0;
      ins1_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      occ_q         <= occ_d;
      pc0_q         <= pc0_d;
      ins0_q        <= ins0_d;
      pc1_q         <= pc1_d;
      ins1_q        <= ins1_d;
      err_q         <= err_d;
    end
  end

  // A response may never arrive into a full buffer that is not being drained.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(inflight_q && !redir_take && (occ_q == 2'd2) && !pop));

  assign imem_addr = fetch_pc_q;
  assign if_valid  = (occ_q != 2'd0);
  assign if_pc     = if_valid ? pc0_q  : 32'd0;
  assign if_instr  = if_valid ? ins0_q : 32'd0;
  assign fetch_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Self-checking bench for fetch_sequencer. A queue-based model
//               of the fetch pipeline predicts every output each cycle;
//               directed phases pin the model with literal values, then a
//               randomized phase exercises ready, redirects and resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned IMEM_BYTES = 64;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer #(
    .RESET_PC   (RESET_PC),
    .IMEM_BYTES (IMEM_BYTES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .fetch_err      (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory: 16 words, word 1 holds a known literal.
  logic [31:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0101_0113);
    mem[1] = 32'h00F0_0093;
  end
  always @(posedge clk) imem_instr <= mem[imem_addr[5:2]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= 32'(IMEM_BYTES - 4));
  endfunction

  // ---------------- reference model ----------------
  // The buffer is a queue of PCs; the instruction for a PC is looked up
  // from the memory contents when it is compared.
  logic [31:0] m_buf [$];
  logic [31:0] m_pc;
  logic [31:0] m_infl_pc;
  bit          m_infl;
  bit          m_halt;
  bit          m_err;
  bit          m_started = 1'b0;

  always @(posedge clk) begin
    logic [31:0] tmp;
    if (reset) begin
      m_started = 1'b1;
      m_pc      = RESET_PC;
      m_buf.delete();
      m_infl    = 1'b0;
      m_infl_pc = '0;
      m_halt    = 1'b0;
      m_err     = 1'b0;
    end else if (m_started) begin
      if (m_buf.size() != 0 && if_ready) tmp = m_buf.pop_front();
      if (!m_halt && redirect_valid) begin
        m_buf.delete();
        m_infl = 1'b0;
        if (legal(redirect_pc)) m_pc = redirect_pc;
        else begin
          m_err  = 1'b1;
          m_halt = 1'b1;
        end
      end else begin
        if (m_infl) m_buf.push_back(m_infl_pc);
        m_infl = 1'b0;
        if (!m_halt) begin
          if (!legal(m_pc)) begin
            m_err  = 1'b1;
            m_halt = 1'b1;
          end else if (m_buf.size() < 2) begin
            m_infl    = 1'b1;
            m_infl_pc = m_pc;
            m_pc      = m_pc + 32'd4;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_started) begin
      check("if_valid", 32'(if_valid), 32'(m_buf.size() != 0));
      check("fetch_err", 32'(fetch_err), 32'(m_err));
      check("imem_addr", imem_addr, m_pc);
      if (m_buf.size() != 0) begin
        check("if_pc", if_pc, m_buf[0]);
        check("if_instr", if_instr, mem[m_buf[0][5:2]]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int halted_cnt;
    int r;
    reset          = 1'b1;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    step();
    step();
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);
    check("rst_addr", imem_addr, RESET_PC);

    // Free run: first instruction visible after two edges.
    reset    = 1'b0;
    if_ready = 1'b1;
    step();
    check("lat_valid0", 32'(if_valid), 32'd0);
    step();
    check("first_pc", if_pc, 32'h00);
    step();
    check("pc_04", if_pc, 32'h04);
    check("instr_04", if_instr, 32'h00F0_0093);
    step();
    check("pc_08", if_pc, 32'h08);

    // Backpressure with 0x08 at the head.
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold", if_pc, 32'h08);
    end
    if_ready = 1'b1;
    step();
    check("bp_pc_0c", if_pc, 32'h0C);
    step();
    check("bp_pc_10", if_pc, 32'h10);

    // Redirect coincident with acceptance of 0x10.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h00;
    step();
    redirect_valid = 1'b0;
    check("rc_flush", 32'(if_valid), 32'd0);
    step();
    step();
    check("rc_pc_00", if_pc, 32'h00);
    step();
    step();
    check("rc_pc_08", if_pc, 32'h08);

    // Redirect while 0x08 is buffered and 0x0C is in flight.
    if_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h24;
    step();
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    check("rd_flush", 32'(if_valid), 32'd0);
    step();
    check("rd_gap", 32'(if_valid), 32'd0);
    step();
    check("rd_pc_24", if_pc, 32'h24);

    // Sequential overrun at the top of memory.
    for (int k = 0; k < 6; k++) begin
      step();
      check("seq_pc", if_pc, 32'h28 + 32'(4 * k));
    end
    check("ovr_err", 32'(fetch_err), 32'd1);
    step();
    check("ovr_drained", 32'(if_valid), 32'd0);

    // Reset mid-stream with a full buffer.
    reset = 1'b1;
    step();
    reset    = 1'b0;
    if_ready = 1'b0;
    step();
    step();
    step();
    check("full_head", if_pc, 32'h00);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mr_valid", 32'(if_valid), 32'd0);
    check("mr_addr", imem_addr, RESET_PC);
    check("mr_err", 32'(fetch_err), 32'd0);
    if_ready = 1'b1;
    step();
    step();
    check("mr_restart", if_pc, RESET_PC);
    step();

    // Misaligned redirect: fault, halt, later redirect ignored.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h22;
    step();
    redirect_valid = 1'b0;
    check("flt_err", 32'(fetch_err), 32'd1);
    check("flt_valid", 32'(if_valid), 32'd0);
    check("flt_addr", imem_addr, 32'h0C);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h00;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    check("flt_ign_valid", 32'(if_valid), 32'd0);
    check("flt_ign_addr", imem_addr, 32'h0C);

    // Randomized phase.
    reset = 1'b1;
    step();
    reset      = 1'b0;
    halted_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = 1'b0;
      reset          = 1'b0;
      r              = int'($urandom_range(0, 199));
      if (r < 2 || halted_cnt > 40) begin
        reset = 1'b1;
      end else if (r < 14) begin
        redirect_valid = 1'b1;
        if ($urandom_range(0, 4) == 0) redirect_pc = 32'($urandom_range(0, 80));
        else                           redirect_pc = 32'($urandom_range(0, 15)) * 32'd4;
      end
      step();
      halted_cnt = m_halt ? halted_cnt + 1 : 0;
    end
    reset          = 1'b0;
    redirect_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Fetch-stage controller that sequences the byte-addressed, big-endian, synchronous-read instruction memory.
- Owns the fetch PC and issues one word address per cycle. Collects the instruction returned one cycle later into a 2-entry buffer.
- Presents {pc, instr} to decode over a valid/ready handshake. Handles redirects (branch/jump) and fetch faults.
- Sits between the instruction memory and the IF/ID pipeline register.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
IMEM_BYTES, 64, instruction memory size in bytes; legal word addresses are 0..IMEM_BYTES-4

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
imem_addr  output  32  word address to instruction memory; memory samples it every posedge
imem_instr  input  32  instruction for the address sampled at the previous posedge
redirect_valid  input  1  single-cycle pulse: restart fetch at redirect_pc
redirect_pc  input  32  redirect target
if_valid  output  1  buffer head holds a valid instruction
if_ready  input  1  decode accepts head this cycle
if_pc  output  32  PC of head instruction
if_instr  output  32  head instruction word
fetch_err  output  1  sticky fault flag (misaligned or out-of-range PC)

Behaviour:
- Reset (sampled at posedge while reset=1):
  - fetch_pc<=RESET_PC; buffer emptied; in-flight request cleared; state<=RUN.
  - Outputs: if_valid=0, if_pc=0, if_instr=0, fetch_err=0, imem_addr=RESET_PC.
  - Reset mid-operation discards all buffered and in-flight instructions.
- imem_addr = fetch_pc (registered; no combinational path from any input).
- State machine, RUN / HALT:
  - RUN: issue allowed.
  - HALT: no issue, fetch_pc frozen, buffer drains normally. Exit only via reset; redirect is ignored in HALT.
- Issue rule (RUN only):
  - issue = (occ + inflight - pop) < 2 and fetch_pc is legal.
  - pop = if_valid & if_ready; occ = buffer occupancy (0..2); inflight = request issued in the previous cycle.
  - On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4. Otherwise inflight<=0.
- Response: when inflight=1, imem_instr is pushed with inflight_pc into the buffer tail in the same cycle.
  - The issue rule guarantees the buffer is never full at a push; an overflow is a design error and is asserted in simulation.
- Latency and throughput:
  - First instruction: if_valid rises 2 cycles after reset deasserts (issue at cycle 0, capture at cycle 1, visible at cycle 2).
  - With if_ready held at 1, one instruction per cycle, PCs strictly +4.
- Handshake:
  - While if_valid=1 and if_ready=0, if_pc and if_instr stay stable.
  - No instruction is lost, duplicated or reordered.
- Buffer: 2-entry FIFO, head drives the if_* outputs.
  - Simultaneous push and pop with occ=2 is impossible; with occ=1 it leaves occupancy unchanged.
- Redirect (priority over issue and push):
  - Any pop in the same cycle completes first. The buffer is then flushed, inflight<=0 (the returning word is dropped) and fetch_pc<=redirect_pc.
  - The first redirected instruction appears on if_valid 2 cycles later.
  - If redirect_pc[1:0]!=0 or redirect_pc>IMEM_BYTES-4: fetch_err<=1, state<=HALT, buffer flushed.
- Sequential overrun:
  - In RUN with fetch_pc>IMEM_BYTES-4 (after +4 increment), no issue is made.
  - fetch_err<=1, state<=HALT; instructions already buffered still drain.
- fetch_err never clears except on reset.
- Arithmetic: fetch_pc+4 is 32-bit unsigned; overflow cannot occur before the range check halts fetch.

Test Plan:
- Free run: memory model preloaded with words at 0x00..0x28, if_ready=1 → if_valid high from cycle 2 after reset, if_pc=0x00,0x04,0x08,… one per cycle, if_instr matches model (e.g. 0x00F00093 at 0x04).
- Backpressure: if_ready=0 for 5 cycles starting when if_pc=0x08 → if_pc/if_instr held at 0x08, occupancy peaks at 2, no issue while full. After release the sequence continues 0x0C,0x10 with no gaps or duplicates.
- Redirect with request in flight: pulse redirect_valid, redirect_pc=0x24, while 0x0C is in flight and 0x08 buffered → 0x08 and 0x0C never appear; 2 cycles later if_pc=0x24, then 0x28.
- Redirect coincident with accept: if_valid=1, if_ready=1, if_pc=0x10, redirect to 0x00 in the same cycle → 0x10 is consumed exactly once, next delivered if_pc=0x00.
- Faults:
  - Redirect to 0x22 → fetch_err=1 next cycle, if_valid=0, imem_addr frozen; a later redirect to 0x00 is ignored until reset.
  - Separately, free run with IMEM_BYTES=64 → 0x3C is delivered, then fetch_err=1 and no further if_valid.
- Reset mid-stream: assert reset for 1 cycle with buffer full (occ=2) → next cycle if_valid=0, imem_addr=RESET_PC, fetch_err=0. Fetch restarts from RESET_PC with the normal 2-cycle latency.
